// File: rtl/csr_unit.sv
// Machine-mode CSR file with trap/MRET sequencing and 64-bit cycle/instret counters.
// sys_instrM_i encoding: 0 = no system op, 1 = ECALL, 2 = EBREAK, 3 = MRET.
module csr_unit #(
  parameter logic [31:0] HART_ID  = 32'd0,
  parameter logic [31:0] MISA_VAL = 32'h4000_0100
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] instrM_i,
  input  logic [1:0]  sys_instrM_i,
  input  logic        csr_readM_i,
  input  logic        csr_writeM_i,
  input  logic [31:0] csr_wdataM_i,
  input  logic [31:0] pcM_i,
  input  logic        validM_i,
  input  logic        stallM_i,
  input  logic        irq_timer_i,
  input  logic        irq_ext_i,
  output logic [31:0] csr_rdataM_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        trap_o
);

  localparam logic [1:0] SysNone   = 2'd0;
  localparam logic [1:0] SysEcall  = 2'd1;
  localparam logic [1:0] SysEbreak = 2'd2;
  localparam logic [1:0] SysMret   = 2'd3;

  localparam logic [11:0] AddrMstatus   = 12'h300;
  localparam logic [11:0] AddrMisa      = 12'h301;
  localparam logic [11:0] AddrMie       = 12'h304;
  localparam logic [11:0] AddrMtvec     = 12'h305;
  localparam logic [11:0] AddrMscratch  = 12'h340;
  localparam logic [11:0] AddrMepc      = 12'h341;
  localparam logic [11:0] AddrMcause    = 12'h342;
  localparam logic [11:0] AddrMtval     = 12'h343;
  localparam logic [11:0] AddrMip       = 12'h344;
  localparam logic [11:0] AddrMcycle    = 12'hB00;
  localparam logic [11:0] AddrMinstret  = 12'hB02;
  localparam logic [11:0] AddrMcycleh   = 12'hB80;
  localparam logic [11:0] AddrMinstreth = 12'hB82;
  localparam logic [11:0] AddrMhartid   = 12'hF14;

  localparam logic [31:0] MieMask  = 32'h0000_0880;
  localparam logic [31:0] LowClear = 32'hFFFF_FFFC;

  // Architectural state
  logic        mie_bit_q, mie_bit_d;
  logic        mpie_q, mpie_d;
  logic [31:0] mie_q, mie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;
  logic        mtip_q, mtip_d;
  logic        meip_q, meip_d;
  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;

  logic [11:0] csr_addr;
  logic [31:0] csr_rdata;
  logic        csr_impl;
  logic [31:0] operand;
  logic [31:0] wval;
  logic        commit;
  logic        illegal;
  logic        take_trap;
  logic        take_mret;
  logic        do_write;
  logic [31:0] cause;

  assign csr_addr = instrM_i[31:20];

  // Read mux: pre-update value of the addressed CSR, plus implemented-address flag
  always_comb begin
    csr_rdata = 32'd0;
    csr_impl  = 1'b1;
    case (csr_addr)
      AddrMstatus:   csr_rdata = {19'd0, 2'b11, 3'd0, mpie_q, 3'd0, mie_bit_q, 3'd0};
      AddrMisa:      csr_rdata = MISA_VAL;
      AddrMie:       csr_rdata = mie_q;
      AddrMtvec:     csr_rdata = mtvec_q;
      AddrMscratch:  csr_rdata = mscratch_q;
      AddrMepc:      csr_rdata = mepc_q;
      AddrMcause:    csr_rdata = mcause_q;
      AddrMtval:     csr_rdata = mtval_q;
      AddrMip:       csr_rdata = {20'd0, meip_q, 3'd0, mtip_q, 7'd0};
      AddrMcycle:    csr_rdata = mcycle_q[31:0];
      AddrMcycleh:   csr_rdata = mcycle_q[63:32];
      AddrMinstret:  csr_rdata = minstret_q[31:0];
      AddrMinstreth: csr_rdata = minstret_q[63:32];
      AddrMhartid:   csr_rdata = HART_ID;
      default:       csr_impl  = 1'b0;
    endcase
  end

  // Write value from funct3: register/immediate operand combined with old value
  always_comb begin
    operand = instrM_i[14] ? {27'd0, instrM_i[19:15]} : csr_wdataM_i;
    case (instrM_i[13:12])
      2'b01:   wval = operand;
      2'b10:   wval = csr_rdata | operand;
      2'b11:   wval = csr_rdata & ~operand;
      default: wval = csr_rdata;
    endcase
  end

  // Commit decode with precedence: illegal CSR > ECALL/EBREAK > MRET > CSR write
  always_comb begin
    commit    = validM_i & ~stallM_i & ~rst_i;
    illegal   = ((csr_readM_i | csr_writeM_i) & ~csr_impl) |
                (csr_writeM_i & (csr_addr[11:10] == 2'b11));
    take_trap = commit & (illegal | (sys_instrM_i == SysEcall) | (sys_instrM_i == SysEbreak));
    take_mret = commit & ~take_trap & (sys_instrM_i == SysMret);
    do_write  = commit & ~take_trap & ~take_mret & (sys_instrM_i == SysNone) & csr_writeM_i;
    if (illegal) begin
      cause = 32'd2;
    end else if (sys_instrM_i == SysEcall) begin
      cause = 32'd11;
    end else begin
      cause = 32'd3;
    end
  end

  // Redirect outputs, only ever asserted in a commit cycle
  always_comb begin
    redirect_o    = take_trap | take_mret;
    trap_o        = take_trap;
    redirect_pc_o = 32'd0;
    if (take_trap) begin
      redirect_pc_o = mtvec_q;
    end else if (take_mret) begin
      redirect_pc_o = mepc_q;
    end
  end

  assign csr_rdataM_o = csr_rdata;

  // Next-state for CSRs and counters
  always_comb begin
    mie_bit_d  = mie_bit_q;
    mpie_d     = mpie_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    mtip_d     = irq_timer_i;
    meip_d     = irq_ext_i;

    // Explicit write to either half wins; the other half holds with no carry
    if (do_write && csr_addr == AddrMcycle) begin
      mcycle_d = {mcycle_q[63:32], wval};
    end else if (do_write && csr_addr == AddrMcycleh) begin
      mcycle_d = {wval, mcycle_q[31:0]};
    end else begin
      mcycle_d = mcycle_q + 64'd1;
    end

    if (do_write && csr_addr == AddrMinstret) begin
      minstret_d = {minstret_q[63:32], wval};
    end else if (do_write && csr_addr == AddrMinstreth) begin
      minstret_d = {wval, minstret_q[31:0]};
    end else if (commit && !take_trap) begin
      minstret_d = minstret_q + 64'd1;
    end else begin
      minstret_d = minstret_q;
    end

    if (take_trap) begin
      mepc_d    = pcM_i & LowClear;
      mcause_d  = cause;
      mtval_d   = illegal ? instrM_i : 32'd0;
      mpie_d    = mie_bit_q;
      mie_bit_d = 1'b0;
    end else if (take_mret) begin
      mie_bit_d = mpie_q;
      mpie_d    = 1'b1;
    end else if (do_write) begin
      case (csr_addr)
        AddrMstatus: begin
          mie_bit_d = wval[3];
          mpie_d    = wval[7];
        end
        AddrMie:      mie_d      = wval & MieMask;
        AddrMtvec:    mtvec_d    = wval & LowClear;
        AddrMscratch: mscratch_d = wval;
        AddrMepc:     mepc_d     = wval & LowClear;
        AddrMcause:   mcause_d   = wval;
        AddrMtval:    mtval_d    = wval;
        default: ;
      endcase
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mie_bit_q  <= 1'b0;
      mpie_q     <= 1'b0;
      mie_q      <= 32'd0;
      mtvec_q    <= 32'd0;
      mscratch_q <= 32'd0;
      mepc_q     <= 32'd0;
      mcause_q   <= 32'd0;
      mtval_q    <= 32'd0;
      mtip_q     <= 1'b0;
      meip_q     <= 1'b0;
      mcycle_q   <= 64'd0;
      minstret_q <= 64'd0;
    end else begin
      mie_bit_q  <= mie_bit_d;
      mpie_q     <= mpie_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      mtip_q     <= mtip_d;
      meip_q     <= meip_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

endmodule

// File: tb/tb_csr_unit.sv
// Self-checking bench for csr_unit: directed scenarios plus randomized traffic
// compared every cycle against a behavioural CSR model.
module tb_csr_unit;

  localparam logic [1:0] NONE = 2'd0, ECALL = 2'd1, EBREAK = 2'd2, MRET = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic [1:0]  sys;
  logic        rd, wr;
  logic [31:0] wdata, pc;
  logic        valid, stall, irq_t, irq_e;
  logic [31:0] rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        trap;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  csr_unit dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .instrM_i     (instr),
    .sys_instrM_i (sys),
    .csr_readM_i  (rd),
    .csr_writeM_i (wr),
    .csr_wdataM_i (wdata),
    .pcM_i        (pc),
    .validM_i     (valid),
    .stallM_i     (stall),
    .irq_timer_i  (irq_t),
    .irq_ext_i    (irq_e),
    .csr_rdataM_o (rdata),
    .redirect_o   (redirect),
    .redirect_pc_o(redirect_pc),
    .trap_o       (trap)
  );

  // Behavioural model state
  bit          m_mie, m_mpie, m_tip, m_eip;
  logic [31:0] m_mie_reg, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  logic [63:0] m_cyc, m_ret;

  // Per-cycle decisions made by compare() and consumed by update()
  bit          e_trap, e_mret, e_write, e_illegal;
  logic [31:0] e_cause, e_wval;

  function automatic bit m_impl(input logic [11:0] a);
    case (a)
      12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344,
      12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
      12'h301: return 32'h4000_0100;
      12'h304: return m_mie_reg;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h344: return (32'(m_eip) << 11) | (32'(m_tip) << 7);
      12'hB00: return m_cyc[31:0];
      12'hB80: return m_cyc[63:32];
      12'hB02: return m_ret[31:0];
      12'hB82: return m_ret[63:32];
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] csr_ins(input logic [11:0] a, input logic [4:0] rs1,
                                          input logic [2:0] f3);
    return {a, rs1, f3, 5'd1, 7'b1110011};
  endfunction

  task automatic m_reset();
    m_mie = 0; m_mpie = 0; m_tip = 0; m_eip = 0;
    m_mie_reg = 0; m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
    m_cyc = 0; m_ret = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Predict outputs from the model and current inputs, then compare against the DUT
  task automatic compare();
    logic [11:0] a;
    logic [31:0] old, opnd, exp_pc;
    bit          commit;
    a       = instr[31:20];
    old     = m_read(a);
    commit  = valid && !stall;
    e_illegal = (rd || wr) && (!m_impl(a) || (wr && a[11:10] == 2'b11));
    e_trap  = commit && (e_illegal || sys == ECALL || sys == EBREAK);
    e_mret  = commit && !e_trap && sys == MRET;
    e_write = commit && !e_trap && !e_mret && sys == NONE && wr;
    e_cause = e_illegal ? 32'd2 : (sys == ECALL ? 32'd11 : 32'd3);
    opnd    = instr[14] ? {27'd0, instr[19:15]} : wdata;
    case (instr[13:12])
      2'b01:   e_wval = opnd;
      2'b10:   e_wval = old | opnd;
      2'b11:   e_wval = old & ~opnd;
      default: e_wval = old;
    endcase
    exp_pc = e_trap ? m_mtvec : (e_mret ? m_mepc : 32'd0);
    chk("rdata", rdata, old);
    chk("redirect", {31'd0, redirect}, {31'd0, e_trap || e_mret});
    chk("trap", {31'd0, trap}, {31'd0, e_trap});
    chk("redirect_pc", redirect_pc, exp_pc);
  endtask

  // Advance the model across one rising edge
  task automatic update();
    logic [11:0] a;
    bit commit;
    a = instr[31:20];
    commit = valid && !stall;
    if (e_write && a == 12'hB00)      m_cyc = {m_cyc[63:32], e_wval};
    else if (e_write && a == 12'hB80) m_cyc = {e_wval, m_cyc[31:0]};
    else                              m_cyc = m_cyc + 1;
    if (e_write && a == 12'hB02)      m_ret = {m_ret[63:32], e_wval};
    else if (e_write && a == 12'hB82) m_ret = {e_wval, m_ret[31:0]};
    else if (commit && !e_trap)       m_ret = m_ret + 1;
    if (e_trap) begin
      m_mepc   = pc & ~32'd3;
      m_mcause = e_cause;
      m_mtval  = e_illegal ? instr : 32'd0;
      m_mpie   = m_mie;
      m_mie    = 0;
    end else if (e_mret) begin
      m_mie  = m_mpie;
      m_mpie = 1;
    end else if (e_write) begin
      case (a)
        12'h300: begin m_mie = e_wval[3]; m_mpie = e_wval[7]; end
        12'h304: m_mie_reg  = e_wval & 32'h880;
        12'h305: m_mtvec    = e_wval & ~32'd3;
        12'h340: m_mscratch = e_wval;
        12'h341: m_mepc     = e_wval & ~32'd3;
        12'h342: m_mcause   = e_wval;
        12'h343: m_mtval    = e_wval;
        default: ;
      endcase
    end
    m_tip = irq_t;
    m_eip = irq_e;
  endtask

  task automatic drive(input logic [31:0] i, input logic [1:0] s, input logic r, input logic w,
                       input logic [31:0] wd, input logic [31:0] p, input logic v,
                       input logic st);
    instr = i; sys = s; rd = r; wr = w; wdata = wd; pc = p; valid = v; stall = st;
  endtask

  task automatic cyc();
    #1;
    compare();
  endtask

  task automatic tick();
    update();
    @(negedge clk);
  endtask

  // Stalled read of one CSR against a literal expectation (no commit)
  task automatic rd_check(input string name, input logic [11:0] a, input logic [31:0] exp);
    drive(csr_ins(a, 5'd0, 3'b010), NONE, 1, 0, 0, 0, 1, 1);
    cyc();
    chk(name, rdata, exp);
    tick();
  endtask

  localparam int NAddr = 19;
  logic [11:0] addr_tab [NAddr] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                    12'h342, 12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02,
                                    12'hB82, 12'hF14, 12'h345, 12'h7C0, 12'hC00, 12'hF11,
                                    12'h306};
  logic [2:0] f3_tab [6] = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};

  initial begin
    logic [1:0]  s;
    logic [31:0] ins;
    int          r;
    rst = 1;
    irq_t = 0; irq_e = 0;
    drive(0, NONE, 0, 0, 0, 0, 0, 0);
    m_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 0;

    // Reset state
    drive(csr_ins(12'h301, 5'd0, 3'b010), NONE, 1, 0, 0, 0, 0, 0);
    cyc();
    chk("reset_misa", rdata, 32'h4000_0100);
    chk("reset_redirect", {31'd0, redirect}, 32'd0);
    chk("reset_trap", {31'd0, trap}, 32'd0);
    chk("reset_pc", redirect_pc, 32'd0);
    tick();
    rd_check("reset_mstatus", 12'h300, 32'h0000_1800);
    rd_check("reset_mhartid", 12'hF14, 32'd0);
    rd_check("reset_mie", 12'h304, 32'd0);
    rd_check("reset_mtvec", 12'h305, 32'd0);
    rd_check("mcycle_after_5", 12'hB00, 32'd5);
    rd_check("minstret_reset", 12'hB02, 32'd0);

    // CSRRW then CSRRS on mscratch
    drive(csr_ins(12'h340, 5'd5, 3'b001), NONE, 1, 1, 32'hDEAD_BEEF, 32'h10, 1, 0);
    cyc(); tick();
    drive(csr_ins(12'h340, 5'd5, 3'b010), NONE, 1, 1, 32'h0000_00F0, 32'h14, 1, 0);
    cyc();
    chk("csrrs_old", rdata, 32'hDEAD_BEEF);
    tick();
    rd_check("mscratch_set", 12'h340, 32'hDEAD_BEFF);

    // MIE=1 via CSRRSI, mtvec=0x103, then ECALL
    drive(csr_ins(12'h300, 5'd8, 3'b110), NONE, 0, 1, 0, 32'h18, 1, 0);
    cyc(); tick();
    drive(csr_ins(12'h305, 5'd6, 3'b001), NONE, 0, 1, 32'h103, 32'h1C, 1, 0);
    cyc(); tick();
    rd_check("mtvec_direct", 12'h305, 32'h100);
    drive(32'h0000_0073, ECALL, 0, 0, 0, 32'h80, 1, 0);
    cyc();
    chk("ecall_redirect", {31'd0, redirect}, 32'd1);
    chk("ecall_trap", {31'd0, trap}, 32'd1);
    chk("ecall_pc", redirect_pc, 32'h100);
    tick();
    rd_check("ecall_mepc", 12'h341, 32'h80);
    rd_check("ecall_mcause", 12'h342, 32'd11);
    rd_check("ecall_mstatus", 12'h300, 32'h1880);
    rd_check("ecall_minstret", 12'hB02, 32'd4);

    // MRET
    drive(32'h3020_0073, MRET, 0, 0, 0, 32'h90, 1, 0);
    cyc();
    chk("mret_redirect", {31'd0, redirect}, 32'd1);
    chk("mret_trap", {31'd0, trap}, 32'd0);
    chk("mret_pc", redirect_pc, 32'h80);
    tick();
    rd_check("mret_mstatus", 12'h300, 32'h1888);
    rd_check("mret_minstret", 12'hB02, 32'd5);

    // Illegal write to mhartid
    drive(32'hF140_1073, NONE, 0, 1, 32'h55, 32'hA0, 1, 0);
    cyc();
    chk("illegal_trap", {31'd0, trap}, 32'd1);
    chk("illegal_pc", redirect_pc, 32'h100);
    tick();
    rd_check("illegal_mcause", 12'h342, 32'd2);
    rd_check("illegal_mtval", 12'h343, 32'hF140_1073);
    rd_check("illegal_mhartid", 12'hF14, 32'd0);
    rd_check("illegal_minstret", 12'hB02, 32'd5);

    // mcycle low-word wrap carries into mcycleh
    drive(csr_ins(12'hB00, 5'd7, 3'b001), NONE, 0, 1, 32'hFFFF_FFFF, 32'hB0, 1, 0);
    cyc(); tick();
    rd_check("mcycle_written", 12'hB00, 32'hFFFF_FFFF);
    rd_check("mcycleh_carry", 12'hB80, 32'd1);
    rd_check("mcycle_wrapped", 12'hB00, 32'd1);

    // Stalled and bubble ECALL: no redirect, no state change
    drive(32'h0000_0073, ECALL, 0, 0, 0, 32'h200, 1, 1);
    cyc();
    chk("stall_redirect", {31'd0, redirect}, 32'd0);
    tick();
    drive(32'h0010_0073, EBREAK, 0, 0, 0, 32'h204, 0, 0);
    cyc();
    chk("bubble_redirect", {31'd0, redirect}, 32'd0);
    tick();
    rd_check("stall_mepc", 12'h341, 32'hA0);

    // mip follows the IRQ lines one cycle later
    irq_t = 1;
    rd_check("mip_latency", 12'h344, 32'd0);
    irq_e = 1;
    rd_check("mip_timer", 12'h344, 32'h80);
    rd_check("mip_both", 12'h344, 32'h880);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        // Asynchronous reset in the middle of a cycle
        drive(csr_ins(12'hB00, 5'd0, 3'b010), NONE, 1, 0, 0, 0, 1, 0);
        #2 rst = 1;
        #1;
        chk("midreset_mcycle", rdata, 32'd0);
        chk("midreset_redirect", {31'd0, redirect}, 32'd0);
        m_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 0;
      end
      r = $urandom_range(0, 99);
      s = (r < 80) ? NONE : (r < 86) ? ECALL : (r < 91) ? EBREAK : MRET;
      ins = csr_ins(addr_tab[$urandom_range(0, NAddr - 1)], 5'($urandom),
                    f3_tab[$urandom_range(0, 5)]);
      if ($urandom_range(0, 15) == 0) irq_t = ~irq_t;
      if ($urandom_range(0, 15) == 0) irq_e = ~irq_e;
      drive(ins, s, 1'($urandom), 1'($urandom), $urandom, $urandom,
            $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 20);
      cyc();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/csr_unit.md
# csr_unit

Machine-mode CSR file and trap/return sequencer for the memory stage of the core pipeline. Consumes the memory-stage instruction word, system-instruction class, and CSR read/write enables produced by the pipeline registers. Returns the old CSR value (`csr_rdataM_o`) for the write-back pipeline. Also drives the PC-redirect request for ECALL/EBREAK/illegal-CSR traps and MRET. Holds the free-running 64-bit cycle and retired-instruction counters.

## Interface
- `HART_ID`, default 0: value returned by mhartid.
- `MISA_VAL`, default 32'h4000_0100: read-only misa value (RV32I).
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_i` in 1: reset, asynchronous and active-high.
- `instrM_i` in 32: memory-stage instruction.
  - CSR address is bits [31:20].
  - rs1/uimm field is bits [19:15].
  - funct3 is bits [14:12].
- `sys_instrM_i` in `exc_t`: NO_SYS, ECALL, EBREAK or MRET.
- `csr_readM_i` in 1: instruction reads a CSR.
- `csr_writeM_i` in 1: instruction writes a CSR. Decode has already cleared this for CSRRS/CSRRC with rs1=x0.
- `csr_wdataM_i` in 32: forwarded rs1 value (register-form CSR ops).
- `pcM_i` in 32: PC of the memory-stage instruction.
- `validM_i` in 1: memory stage holds a real instruction, not a bubble.
- `stallM_i` in 1: memory stage stalled; no commit this cycle.
- `irq_timer_i`, `irq_ext_i` in 1 each: level inputs mirrored into mip.MTIP (bit 7) and mip.MEIP (bit 11).
- `csr_rdataM_o` out 32: pre-update value of the addressed CSR.
- `redirect_o` out 1: take a PC redirect this cycle.
- `redirect_pc_o` out 32: redirect target.
- `trap_o` out 1: redirect is a trap entry.

## Operation
- Commit is `validM_i & ~stallM_i`. All architectural side effects happen only on commit.
- Implemented CSRs:
  - mstatus (0x300): MIE bit 3 and MPIE bit 7 are R/W. MPP [12:11] reads 2'b11. Other bits read 0.
  - misa (0x301): writes ignored.
  - mie (0x304): only bits 7 and 11 are writable.
  - mtvec (0x305): bits [1:0] read 0 (direct mode).
  - mscratch (0x340): full R/W.
  - mepc (0x341): bits [1:0] read 0.
  - mcause (0x342): full R/W.
  - mtval (0x343): full R/W.
  - mip (0x344): read-only.
  - mcycle/mcycleh (0xB00/0xB80): R/W.
  - minstret/minstreth (0xB02/0xB82): R/W.
  - mhartid (0xF14): read-only.
- Write operand and write value by funct3:
  - funct3[2]=0: operand is `csr_wdataM_i`.
  - funct3[2]=1: operand is the zero-extended 5-bit uimm.
  - funct3[1:0]=01: new value = operand.
  - funct3[1:0]=10: new value = old | operand.
  - funct3[1:0]=11: new value = old & ~operand.
- Illegal CSR access:
  - Occurs when `csr_readM_i|csr_writeM_i` and the address is unimplemented.
  - Also occurs when `csr_writeM_i` and address[11:10]=2'b11.
  - An illegal access is a trap with cause 2 and mtval = `instrM_i`. The CSR write is suppressed.
- Trap entry (ECALL cause 11, EBREAK cause 3, or illegal CSR cause 2):
  - mepc <= `pcM_i`, mcause <= cause.
  - mtval <= 0 for ECALL/EBREAK.
  - MPIE <= MIE, then MIE <= 0.
  - Outputs: `redirect_o=1`, `trap_o=1`, `redirect_pc_o` = {mtvec[31:2],2'b00}.
- MRET:
  - MIE <= MPIE, MPIE <= 1.
  - Outputs: `redirect_o=1`, `trap_o=0`, `redirect_pc_o` = mepc.
- Counters:
  - mcycle increments every cycle, including during stalls.
  - minstret increments on each commit that does not trap. MRET counts as retired.
  - Both counters are 64-bit with a carry from the low word into the high word.
  - An explicit write to either half wins over the increment in that cycle. The other half keeps its value; there is no carry that cycle.
- Precedence within one commit: illegal-CSR trap > ECALL/EBREAK > MRET > CSR write.

## Timing
- `csr_rdataM_o` is combinational from `instrM_i[31:20]` and current state. It shows the value before this cycle's update.
- `redirect_o`, `redirect_pc_o` and `trap_o` are combinational and asserted only in a commit cycle. They are 0 when `stallM_i=1` or `validM_i=0`.
- All CSR updates become visible on the edge after commit. A back-to-back CSR read one cycle later sees the new value.
- Reset values: all CSRs 0 except misa=`MISA_VAL` and mhartid=`HART_ID`. MPP reads 2'b11. Outputs deasserted, `redirect_pc_o`=0.
- A reset asserted mid-operation clears counters and state immediately. No partial trap is recorded.
- mip tracks the IRQ inputs with one register stage (1-cycle latency).

## Test plan
- After reset, read mcycle with a stall held 5 cycles -> returns the cycle count since reset release; minstret=0.
- CSRRW mscratch with 0xDEADBEEF, then CSRRS mscratch with 0x0000_00F0 -> the second read returns 0xDEADBEEF; mscratch becomes 0xDEADBEFF.
- MIE=1, ECALL at pcM=0x80 with mtvec=0x103 -> `redirect_pc_o`=0x100, `trap_o`=1. Next cycle: mepc=0x80, mcause=11, MIE=0, MPIE=1.
- MRET after the previous test -> `redirect_pc_o`=0x80, `trap_o`=0. Next cycle: MIE=1, MPIE=1; minstret incremented.
- CSRRW to mhartid (0xF14) with instr 0xF1401073 -> trap with mcause=2, mtval=0xF1401073; mhartid unchanged; minstret not incremented.
- Write mcycle=0xFFFF_FFFF -> the following cycle mcycle=0 and mcycleh increments by 1. Commit held off by stall -> no redirect and no state change besides mcycle.
